dcache_dump_ctrl: RTL and testbench

- Post-run data-cache drain engine. Sits directly downstream of the processor's data cache read port.
- On a start pulse, it walks a contiguous word range of the data cache and streams each word, with its address, over a valid/ready interface.
- Used by the simulation bench and the board-level harness to extract results, such as Fibonacci output arrays, after the program halts.
- Owns the cache read port only while busy; the core must be halted while it runs.

---
 rtl/dcache_dump_if.sv | 31 +++
 rtl/dcache_dump_ctrl.sv | 90 +++++++++
 tb/tb_dcache_dump_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_dump_if.sv
// dcache_dump_if: cache read port plus valid/ready dump stream.
// master = dump controller, slave = cache + stream sink.
//   mem_rd_en   : cache read strobe.
//   mem_addr    : cache read address.
//   mem_rd_data : read data, valid one cycle after mem_rd_en.
//   out_valid   : stream word valid.
//   out_ready   : stream sink ready.
//   out_addr    : address of out_data.
//   out_data    : dumped word.
//   out_last    : final word of the dump.
interface dcache_dump_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    modport master (
        output mem_rd_en, mem_addr, out_valid, out_addr, out_data, out_last,
        input  mem_rd_data, out_ready
    );
    modport slave (
        input  mem_rd_en, mem_addr, out_valid, out_addr, out_data, out_last,
        output mem_rd_data, out_ready
    );
endinterface

// File: rtl/dcache_dump_ctrl.sv
// dcache_dump_ctrl: post-run data-cache drain engine streaming a word range as (addr, data).
// Ports:
//   clk, nrst       : clock, asynchronous active-low reset.
//   start           : one-cycle request, honoured only when idle.
//   base_addr       : first word address, sampled with start.
//   word_count      : number of words, sampled with start (0 = no-op dump).
//   bus             : dcache_dump_if.master (cache read port + output stream).
//   busy            : dump in progress (READ/CAPT/SEND/FIN).
//   done            : one-cycle completion pulse.
//   checksum        : sum of transferred words, only with DCACHE_DUMP_CHECKSUM_EN defined.
module dcache_dump_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    dcache_dump_if.master         bus,
    output logic                  busy,
    output logic                  done
`ifdef DCACHE_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);
    typedef enum logic [2:0] {IDLE, READ, CAPT, SEND, FIN} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  rem;
    logic accept, xfer, last;
    assign accept = state == IDLE && start;
    assign xfer   = state == SEND && bus.out_valid && bus.out_ready;
    assign last   = rem == CNT_WIDTH'(1);
    // addr only changes on entry to READ, so it doubles as the held cache address
    assign bus.mem_rd_en = state == READ;
    assign bus.mem_addr  = addr;
    assign busy = state != IDLE;
    assign done = state == FIN;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !start ? IDLE : (word_count == '0 ? FIN : READ);
            READ:    state_nx = CAPT;
            CAPT:    state_nx = SEND;
            SEND:    state_nx = !xfer ? SEND : (last ? FIN : READ);
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr          <= '0;
            rem           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
`ifdef DCACHE_DUMP_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            if (accept && word_count != '0) begin
                addr <= base_addr;
                rem  <= word_count;
            end
            if (state == CAPT) begin
                bus.out_data  <= bus.mem_rd_data;
                bus.out_addr  <= addr;
                bus.out_last  <= last;
                bus.out_valid <= 1'b1;
            end
            if (xfer) begin
                bus.out_valid <= 1'b0;
                rem           <= rem - 1'b1;
                if (!last) addr <= addr + 1'b1;
            end
`ifdef DCACHE_DUMP_CHECKSUM_EN
            if (accept)    checksum <= '0;
            else if (xfer) checksum <= checksum + bus.out_data;
`endif
        end
    end
endmodule

// File: tb/tb_dcache_dump_ctrl.sv
// tb_dcache_dump_ctrl: randomized self-checking bench for dcache_dump_ctrl against a word-list model.
module tb_dcache_dump_ctrl;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int CW = AW + 1;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } item_t;
    typedef item_t q_t[$];

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic busy, done;
`ifdef DCACHE_DUMP_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    dcache_dump_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dcache_dump_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .nrst(nrst),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .bus(bus.master),
        .busy(busy),
        .done(done)
`ifdef DCACHE_DUMP_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

    int checks = 0;
    int failures = 0;
    item_t obs[$];
    q_t exp;
    int cycles, first_v, rd_cnt, valid_seen, done_cnt, done_at, stab_err;
    bit timed_out;

    // expected stream: word i comes from (base+i) mod depth, last flag on the final one
    function automatic q_t model(input int base, input int cnt);
        q_t q;
        for (int i = 0; i < cnt; i++) begin
            int a;
            a = (base + i) % DEPTH;
            q.push_back(item_t'({AW'(a), mem[a], i == cnt - 1}));
        end
        return q;
    endfunction

    function automatic logic [DW-1:0] model_sum(input q_t q);
        logic [DW-1:0] s;
        s = '0;
        foreach (q[i]) s += q[i].d;
        return s;
    endfunction

    // runs one dump, recording transfers; ready pattern: 0 = always, 1 = toggle every 2, 2 = random
    task automatic run_dump(input int base, input int cnt, input int mode, input bit inj);
        logic pv, pr, pl, r;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        obs.delete();
        first_v = -1; rd_cnt = 0; valid_seen = 0; done_cnt = 0; done_at = -1; stab_err = 0; timed_out = 0;
        pv = 0; pr = 0; pl = 0; pa = '0; pd = '0;
        @(negedge clk);
        start = 1'b1; base_addr = AW'(base); word_count = CW'(cnt); bus.out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (1) begin
            if (bus.mem_rd_en) rd_cnt++;
            if (bus.out_valid) begin
                valid_seen++;
                if (first_v < 0) first_v = cycles;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cycles;
            end
            if (pv && !pr && (!bus.out_valid || bus.out_addr !== pa || bus.out_data !== pd || bus.out_last !== pl))
                stab_err++;
            r = mode == 0 ? 1'b1 : mode == 1 ? 1'(((cycles / 2) % 2) == 1) : 1'($urandom_range(0, 1));
            bus.out_ready = r;
            if (bus.out_valid && r) obs.push_back(item_t'({bus.out_addr, bus.out_data, bus.out_last}));
            pv = bus.out_valid; pr = r; pa = bus.out_addr; pd = bus.out_data; pl = bus.out_last;
            if (inj) begin
                start = cycles == 5;
                if (cycles == 5) begin
                    base_addr = AW'(base + 100);
                    word_count = CW'(1);
                end
            end
            if (done_at >= 0 && cycles >= done_at + 6) break;
            if (cycles >= 30000) begin
                timed_out = 1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({bus.mem_rd_en, bus.out_valid, bus.out_last, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got rd_en=%b valid=%b last=%b busy=%b done=%b exp all 0",
                     bus.mem_rd_en, bus.out_valid, bus.out_last, busy, done);
        end
        checks++;
        if (bus.mem_addr !== '0 || bus.out_addr !== '0 || bus.out_data !== '0) begin
            failures++;
            $display("FAIL reset_data got mem_addr=%h out_addr=%h out_data=%h exp 0",
                     bus.mem_addr, bus.out_addr, bus.out_data);
        end
`ifdef DCACHE_DUMP_CHECKSUM_EN
        checks++;
        if (checksum !== '0) begin
            failures++;
            $display("FAIL reset_checksum got=%h exp=0", checksum);
        end
`endif
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b valid=%b exp 0 0", busy, bus.out_valid);
        end
    endtask

    task automatic test_basic;
        int fib[8] = '{0, 1, 1, 2, 3, 5, 8, 13};
        foreach (fib[i]) mem[i] = DW'(fib[i]);
        exp = model(0, 8);
        run_dump(0, 8, 0, 0);
        checks++;
        if (timed_out || obs.size() != 8) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=8 timeout=%0d", obs.size(), timed_out);
        end
        foreach (exp[i]) begin
            checks++;
            if (obs[i] !== exp[i]) begin
                failures++;
                $display("FAIL basic_word[%0d] got=%h exp=%h", i, obs[i], exp[i]);
            end
        end
        checks++;
        if (first_v != 2 || done_at != 24 || done_cnt != 1) begin
            failures++;
            $display("FAIL basic_timing got first_valid=%0d done_at=%0d done_cnt=%0d exp 2 24 1",
                     first_v, done_at, done_cnt);
        end
        checks++;
        if (rd_cnt != 8) begin
            failures++;
            $display("FAIL basic_reads got=%0d exp=8", rd_cnt);
        end
`ifdef DCACHE_DUMP_CHECKSUM_EN
        checks++;
        if (checksum !== DW'(33)) begin
            failures++;
            $display("FAIL basic_checksum got=%0d exp=33", checksum);
        end
`endif
    endtask

    task automatic test_backpressure;
        exp = model(0, 8);
        run_dump(0, 8, 1, 0);
        checks++;
        if (timed_out || obs.size() != 8) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=8 timeout=%0d", obs.size(), timed_out);
        end
        foreach (exp[i]) begin
            checks++;
            if (obs[i] !== exp[i]) begin
                failures++;
                $display("FAIL bp_word[%0d] got=%h exp=%h", i, obs[i], exp[i]);
            end
        end
        checks++;
        if (stab_err != 0 || done_cnt != 1 || first_v != 2) begin
            failures++;
            $display("FAIL bp_protocol got stall_changes=%0d done_cnt=%0d first_valid=%0d exp 0 1 2",
                     stab_err, done_cnt, first_v);
        end
`ifdef DCACHE_DUMP_CHECKSUM_EN
        checks++;
        if (checksum !== model_sum(exp)) begin
            failures++;
            $display("FAIL bp_checksum got=%h exp=%h", checksum, model_sum(exp));
        end
`endif
    endtask

    task automatic test_zero_count;
        run_dump(int'($urandom_range(0, DEPTH - 1)), 0, 0, 0);
        checks++;
        if (timed_out || rd_cnt != 0 || valid_seen != 0) begin
            failures++;
            $display("FAIL zero_activity got reads=%0d valids=%0d timeout=%0d exp 0 0 0",
                     rd_cnt, valid_seen, timed_out);
        end
        checks++;
        if (done_cnt != 1 || done_at != 0) begin
            failures++;
            $display("FAIL zero_done got done_cnt=%0d done_at=%0d exp 1 0", done_cnt, done_at);
        end
`ifdef DCACHE_DUMP_CHECKSUM_EN
        checks++;
        if (checksum !== '0) begin
            failures++;
            $display("FAIL zero_checksum got=%h exp=0", checksum);
        end
`endif
    endtask

    task automatic test_wrap;
        exp = model(1022, 4);
        run_dump(1022, 4, 2, 0);
        checks++;
        if (timed_out || obs.size() != 4) begin
            failures++;
            $display("FAIL wrap_count got=%0d exp=4 timeout=%0d", obs.size(), timed_out);
        end
        foreach (exp[i]) begin
            checks++;
            if (obs[i] !== exp[i]) begin
                failures++;
                $display("FAIL wrap_word[%0d] got=%h exp=%h", i, obs[i], exp[i]);
            end
        end
        checks++;
        if (stab_err != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL wrap_protocol got stall_changes=%0d done_cnt=%0d exp 0 1", stab_err, done_cnt);
        end
    endtask

    task automatic test_start_while_busy;
        int b;
        b = int'($urandom_range(0, DEPTH - 1));
        exp = model(b, 5);
        run_dump(b, 5, 0, 1);
        checks++;
        if (timed_out || obs.size() != 5 || done_cnt != 1) begin
            failures++;
            $display("FAIL busy_start_count got words=%0d done_cnt=%0d exp 5 1", obs.size(), done_cnt);
        end
        foreach (exp[i]) begin
            checks++;
            if (obs[i] !== exp[i]) begin
                failures++;
                $display("FAIL busy_start_word[%0d] got=%h exp=%h", i, obs[i], exp[i]);
            end
        end
`ifdef DCACHE_DUMP_CHECKSUM_EN
        checks++;
        if (checksum !== model_sum(exp)) begin
            failures++;
            $display("FAIL busy_start_checksum got=%h exp=%h", checksum, model_sum(exp));
        end
`endif
    endtask

    task automatic test_random;
        for (int t = 0; t < 5; t++) begin
            int b, n, md;
            b = int'($urandom_range(0, DEPTH - 1));
            n = t == 4 ? 1030 : int'($urandom_range(1, 40));
            md = t == 4 ? 0 : 2;
            exp = model(b, n);
            run_dump(b, n, md, 0);
            checks++;
            if (timed_out || obs.size() != n || done_cnt != 1 || stab_err != 0) begin
                failures++;
                $display("FAIL rand%0d_protocol got words=%0d done_cnt=%0d stall_changes=%0d exp %0d 1 0",
                         t, obs.size(), done_cnt, stab_err, n);
            end
            foreach (exp[i]) begin
                checks++;
                if (obs[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL rand%0d_word[%0d] got=%h exp=%h", t, i, obs[i], exp[i]);
                end
            end
            if (md == 0) begin
                checks++;
                if (done_at != 3 * n || rd_cnt != n) begin
                    failures++;
                    $display("FAIL rand%0d_timing got done_at=%0d reads=%0d exp %0d %0d",
                             t, done_at, rd_cnt, 3 * n, n);
                end
            end
`ifdef DCACHE_DUMP_CHECKSUM_EN
            checks++;
            if (checksum !== model_sum(exp)) begin
                failures++;
                $display("FAIL rand%0d_checksum got=%h exp=%h", t, checksum, model_sum(exp));
            end
`endif
        end
    endtask

    task automatic test_reset_mid_dump;
        int b, dn;
        b = int'($urandom_range(0, DEPTH - 1));
        @(negedge clk);
        start = 1'b1; base_addr = AW'(b); word_count = CW'(6); bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== AW'(b + 2)) begin
            failures++;
            $display("FAIL mid_pre got valid=%b addr=%h exp 1 %h", bus.out_valid, bus.out_addr, AW'(b + 2));
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({bus.mem_rd_en, bus.out_valid, bus.out_last, busy, done} !== 5'b0 ||
            bus.mem_addr !== '0 || bus.out_addr !== '0 || bus.out_data !== '0) begin
            failures++;
            $display("FAIL mid_reset got rd_en=%b valid=%b last=%b busy=%b done=%b maddr=%h oaddr=%h data=%h exp all 0",
                     bus.mem_rd_en, bus.out_valid, bus.out_last, busy, done, bus.mem_addr, bus.out_addr, bus.out_data);
        end
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        nrst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if (dn != 0) begin
            failures++;
            $display("FAIL mid_no_done got done_pulses=%0d exp=0", dn);
        end
        b = int'($urandom_range(0, DEPTH - 1));
        exp = model(b, 6);
        run_dump(b, 6, 0, 0);
        checks++;
        if (timed_out || obs.size() != 6 || done_cnt != 1 || done_at != 18) begin
            failures++;
            $display("FAIL post_reset_run got words=%0d done_cnt=%0d done_at=%0d exp 6 1 18",
                     obs.size(), done_cnt, done_at);
        end
        foreach (exp[i]) begin
            checks++;
            if (obs[i] !== exp[i]) begin
                failures++;
                $display("FAIL post_reset_word[%0d] got=%h exp=%h", i, obs[i], exp[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_wrap();
        test_start_while_busy();
        test_random();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
